// File: rtl/alu_pkg.sv
// Shared types for the issue controller: ALU op codes, FSM states, instruction
// field positions and the op-index decode used by alu_issue_ctrl.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND = 5'b00000,
    OP_OR  = 5'b00001,
    OP_NOT = 5'b00010,
    OP_XOR = 5'b00011,
    OP_ADD = 5'b00100,
    OP_SUB = 5'b00101,
    OP_LSL = 5'b10000,
    OP_LSR = 5'b10001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Sub-class of insn[8]=1 instructions, held in insn[7:6]
  typedef enum logic [1:0] {
    K_LDI = 2'b00,
    K_CMP = 2'b01,
    K_BEQ = 2'b10,
    K_BLT = 2'b11
  } kind_e;

  localparam int unsigned INSN_W  = 9;
  localparam int unsigned B_CLASS = 8;
  localparam int unsigned B_BAD   = 0;
  localparam int unsigned OP_HI   = 7;
  localparam int unsigned OP_LO   = 5;
  localparam int unsigned RD_HI   = 4;
  localparam int unsigned RD_LO   = 3;
  localparam int unsigned RS_HI   = 2;
  localparam int unsigned RS_LO   = 1;

  function automatic alu_op_e idx_to_op(input logic [2:0] idx);
    alu_op_e op;
    op = OP_AND;
    unique case (idx)
      3'd0: op = OP_AND;
      3'd1: op = OP_OR;
      3'd2: op = OP_NOT;
      3'd3: op = OP_XOR;
      3'd4: op = OP_ADD;
      3'd5: op = OP_SUB;
      3'd6: op = OP_LSL;
      3'd7: op = OP_LSR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Fetch-side instruction handshake between instruction fetch and alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic [8:0] insn;
  logic       insn_valid;
  logic       insn_ready;

  modport master (output insn, output insn_valid, input  insn_ready);
  modport slave  (input  insn, input  insn_valid, output insn_ready);
endinterface

// File: rtl/alu_issue_ctrl_regfile4x8.sv
// Async-reset register array: one write port, two operand read ports and a
// debug read port, all reads combinational.
module regfile4x8 #(
  parameter int unsigned NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  output logic [7:0]               rdata_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [7:0]               rdata_b,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  logic [7:0] mem_q [NREGS];
  logic [7:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata_a  = mem_q[raddr_a];
  assign rdata_b  = mem_q[raddr_b];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-phase issue/writeback controller driving an 8-bit combinational ALU:
// decode and operand fetch on accept, result capture in EXEC, writeback in WB.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned NREGS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave fetch,
  output logic [7:0]      alu_in1,
  output logic [7:0]      alu_in2,
  output logic [4:0]      alu_op,
  input  logic [7:0]      alu_out,
  input  logic            alu_equal,
  input  logic            alu_less,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic            err,
  input  logic [1:0]      dbg_addr,
  output logic [7:0]      dbg_data
);

  state_e            state_q, state_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic [7:0]        in1_q, in1_d, in2_q, in2_d, res_q, res_d;
  alu_op_e           op_q, op_d, dec_op;
  logic              eq_q, eq_d, lt_q, lt_d, peq_q, peq_d, plt_q, plt_d;
  logic [PC_W-1:0]   pc_q, pc_d, br_off;
  logic [1:0]        raddr_a, raddr_b, waddr;
  logic [7:0]        rdata_a, rdata_b, wdata;
  logic              we, taken, illegal;
  logic [1:0]        unused_rs;

  // Operands are read from the incoming word so they are registered and
  // stable for the whole EXEC cycle.
  assign raddr_a = fetch.insn[B_CLASS] ? fetch.insn[5:4] : fetch.insn[RD_HI:RD_LO];
  assign raddr_b = fetch.insn[B_CLASS] ? fetch.insn[3:2] : fetch.insn[RS_HI:RS_LO];
  assign dec_op  = idx_to_op(fetch.insn[OP_HI:OP_LO]);
  assign illegal = !insn_q[B_CLASS] && insn_q[B_BAD];
  assign br_off  = PC_W'($signed(insn_q[5:0]));
  assign unused_rs = insn_q[RS_HI:RS_LO];

  regfile4x8 #(.NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    res_d   = res_q;
    peq_d   = peq_q;
    plt_d   = plt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    pc_d    = pc_q;
    we      = 1'b0;
    waddr   = insn_q[RD_HI:RD_LO];
    wdata   = res_q;
    taken   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch.insn_valid) begin
          insn_d  = fetch.insn;
          state_d = EXEC;
          if (!fetch.insn[B_CLASS]) begin
            op_d  = dec_op;
            in1_d = rdata_a;
            in2_d = (dec_op == OP_NOT) ? '0 : rdata_b;
          end else if (kind_e'(fetch.insn[7:6]) == K_CMP) begin
            op_d  = OP_SUB;
            in1_d = rdata_a;
            in2_d = rdata_b;
          end else begin
            op_d  = OP_AND;
            in1_d = '0;
            in2_d = '0;
          end
        end
      end
      EXEC: begin
        res_d   = alu_out;
        peq_d   = alu_equal;
        plt_d   = alu_less;
        state_d = WB;
      end
      WB: begin
        state_d = IDLE;
        if (!insn_q[B_CLASS]) begin
          we = !illegal;
        end else begin
          unique case (kind_e'(insn_q[7:6]))
            K_LDI: begin
              we    = 1'b1;
              waddr = insn_q[5:4];
              wdata = {4'b0000, insn_q[3:0]};
            end
            K_CMP: begin
              eq_d = peq_q;
              lt_d = plt_q;
            end
            K_BEQ: taken = eq_q;
            K_BLT: taken = lt_q;
          endcase
        end
        pc_d = taken ? pc_q + br_off : pc_q + PC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      insn_q  <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= OP_AND;
      res_q   <= '0;
      peq_q   <= 1'b0;
      plt_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      res_q   <= res_d;
      peq_q   <= peq_d;
      plt_q   <= plt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch.insn_ready = (state_q == IDLE);
  assign done    = (state_q == WB);
  assign err     = done && illegal;
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;
  assign alu_op  = op_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, architectural
// reference model compared every cycle, plus directed literal expectations.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic [4:0] alu_op;
  logic       alu_equal, alu_less;
  logic [7:0] pc;
  logic       done, err;
  logic [1:0] dbg_addr = 2'd0;
  logic [7:0] dbg_data;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;

  alu_issue_ctrl_if fif ();

  alu_issue_ctrl #(.PC_W(8), .NREGS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (fif),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_equal (alu_equal),
    .alu_less  (alu_less),
    .pc        (pc),
    .done      (done),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  // The ALU that sits on the other side of the controller
  always_comb begin
    case (alu_op)
      5'h00:   alu_out = alu_in1 & alu_in2;
      5'h01:   alu_out = alu_in1 | alu_in2;
      5'h02:   alu_out = ~alu_in1;
      5'h03:   alu_out = alu_in1 ^ alu_in2;
      5'h04:   alu_out = alu_in1 + alu_in2;
      5'h05:   alu_out = alu_in1 - alu_in2;
      5'h10:   alu_out = alu_in1 << alu_in2;
      5'h11:   alu_out = alu_in1 >> alu_in2;
      default: alu_out = 8'h00;
    endcase
  end
  assign alu_equal = (alu_in1 == alu_in2);
  assign alu_less  = (alu_in1 < alu_in2);

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_r [4] = '{default: 8'h00};
  logic [7:0] m_pc = 8'h00;
  logic [8:0] m_insn = 9'h000;
  int         m_phase = 0;
  bit         m_eq = 1'b0, m_lt = 1'b0;
  logic [4:0] optab [8] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h10, 5'h11};

  function automatic logic [7:0] arith(input int idx, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (idx)
      0: s = a & b;
      1: s = a | b;
      2: s = 255 - a;
      3: s = a ^ b;
      4: s = (int'(a) + int'(b)) % 256;
      5: s = (int'(a) - int'(b) + 256) % 256;
      6: s = (b > 7) ? 0 : (int'(a) * (1 << b)) % 256;
      default: s = (b > 7) ? 0 : int'(a) / (1 << b);
    endcase
    return 8'(s);
  endfunction

  task automatic retire(input logic [8:0] w);
    int idx, off;
    logic [7:0] a, b;
    off = int'(w[5:0]);
    if (w[5]) off = off - 64;
    if (!w[8]) begin
      if (!w[0]) begin
        idx = int'(w[7:5]);
        a = m_r[w[4:3]];
        b = (idx == 2) ? 8'h00 : m_r[w[2:1]];
        m_r[w[4:3]] = arith(idx, a, b);
      end
      m_pc = m_pc + 8'd1;
    end else begin
      case (w[7:6])
        2'b00: begin m_r[w[5:4]] = {4'h0, w[3:0]}; m_pc = m_pc + 8'd1; end
        2'b01: begin
          m_eq = (m_r[w[5:4]] == m_r[w[3:2]]);
          m_lt = (m_r[w[5:4]] <  m_r[w[3:2]]);
          m_pc = m_pc + 8'd1;
        end
        default: begin
          if ((w[7:6] == 2'b10) ? m_eq : m_lt) m_pc = 8'((int'(m_pc) + off + 256) % 256);
          else m_pc = m_pc + 8'd1;
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r = '{default: 8'h00};
      m_pc = 8'h00; m_eq = 1'b0; m_lt = 1'b0; m_phase = 0;
    end else if (m_phase == 0) begin
      if (fif.insn_valid) begin m_insn = fif.insn; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      retire(m_insn);
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    check("ready", fif.insn_ready, m_phase == 0);
    check("done", done, m_phase == 2);
    check("err", err, (m_phase == 2) && !m_insn[8] && m_insn[0]);
    check("pc", pc, m_pc);
    check("dbg", dbg_data, m_r[dbg_addr]);
    if (m_phase == 1 && !m_insn[8] && !m_insn[0]) begin
      check("alu_op", alu_op, optab[m_insn[7:5]]);
      check("alu_in1", alu_in1, m_r[m_insn[4:3]]);
      check("alu_in2", alu_in2, (m_insn[7:5] == 3'd2) ? 8'h00 : m_r[m_insn[2:1]]);
    end
    if (m_phase == 1 && m_insn[8:6] == 3'b101) begin
      check("cmp_op", alu_op, 5'h05);
      check("cmp_in1", alu_in1, m_r[m_insn[5:4]]);
      check("cmp_in2", alu_in2, m_r[m_insn[3:2]]);
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [8:0] alu_i(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic bad);
    return {1'b0, op, rd, rs, bad};
  endfunction
  function automatic logic [8:0] ldi(input logic [1:0] r, input logic [3:0] imm);
    return {3'b100, r, imm};
  endfunction
  function automatic logic [8:0] cmp(input logic [1:0] a, input logic [1:0] b);
    return {3'b101, a, b, 2'b00};
  endfunction
  function automatic logic [8:0] beq(input logic [5:0] off);
    return {3'b110, off};
  endfunction
  function automatic logic [8:0] blt(input logic [5:0] off);
    return {3'b111, off};
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic issue(input logic [8:0] w, input bit hold = 1'b0, input logic [8:0] nxt = 9'h000);
    int n = 0;
    fif.insn = w;
    fif.insn_valid = 1'b1;
    @(negedge clk);
    while (!fif.insn_ready) begin
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL accept_timeout: insn %0h not accepted within 20 cycles", w);
        fif.insn_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (hold) fif.insn = nxt;
    else      fif.insn_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      dbg_addr = dbg_addr + 2'd1;
    end
  endtask

  task automatic expect_reg(input string nm, input logic [1:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1 check(nm, dbg_data, v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int dc0, ec0;

  initial begin
    fif.insn = 9'h000;
    fif.insn_valid = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_pc", pc, 8'h00);
    check("rst_ready", fif.insn_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_in1", alu_in1, 8'h00);
    check("rst_in2", alu_in2, 8'h00);
    check("rst_op", alu_op, 5'h00);
    rst_n = 1'b1;

    // LDI / ADD basics
    issue(ldi(2'd1, 4'd5));
    issue(ldi(2'd2, 4'd3));
    issue(alu_i(3'd4, 2'd1, 2'd2, 1'b0));
    expect_reg("add_r1", 2'd1, 8'h08);
    check("add_pc", pc, 8'h03);
    check("add_done_cnt", done_cnt, 3);

    // SUB wrap, doubling, 0xFF+1, shifts and logic ops
    issue(ldi(2'd1, 4'd3));
    issue(ldi(2'd2, 4'd5));
    issue(alu_i(3'd5, 2'd1, 2'd2, 1'b0));
    expect_reg("sub_r1", 2'd1, 8'hFE);
    issue(ldi(2'd3, 4'hF));
    repeat (4) issue(alu_i(3'd4, 2'd3, 2'd3, 1'b0));
    expect_reg("dbl_r3", 2'd3, 8'hF0);
    issue(ldi(2'd2, 4'd1));
    issue(alu_i(3'd4, 2'd1, 2'd2, 1'b0));
    expect_reg("ff_r1", 2'd1, 8'hFF);
    issue(alu_i(3'd4, 2'd1, 2'd2, 1'b0));
    expect_reg("wrap_r1", 2'd1, 8'h00);
    issue(ldi(2'd0, 4'd9));
    issue(alu_i(3'd6, 2'd3, 2'd0, 1'b0));
    expect_reg("lsl9_r3", 2'd3, 8'h00);
    issue(ldi(2'd0, 4'd2));
    issue(ldi(2'd2, 4'hC));
    issue(alu_i(3'd7, 2'd2, 2'd0, 1'b0));
    expect_reg("lsr_r2", 2'd2, 8'h03);
    issue(alu_i(3'd2, 2'd2, 2'd2, 1'b0));
    expect_reg("not_r2", 2'd2, 8'hFC);
    issue(ldi(2'd3, 4'd5));
    issue(alu_i(3'd3, 2'd2, 2'd3, 1'b0));
    issue(alu_i(3'd0, 2'd2, 2'd3, 1'b0));
    issue(alu_i(3'd1, 2'd2, 2'd0, 1'b0));
    expect_reg("logic_r2", 2'd2, 8'h03);
    check("no_err_yet", err_cnt, 0);

    // CMP equal, taken BEQ back, untaken BLT
    do_reset();
    issue(ldi(2'd0, 4'd4));
    issue(ldi(2'd1, 4'd4));
    issue(cmp(2'd0, 2'd1));
    issue(beq(6'h3E));
    check("beq_taken_pc", pc, 8'h01);
    issue(blt(6'h05));
    check("blt_untaken_pc", pc, 8'h02);

    // Branch wrap around pc=0
    do_reset();
    issue(ldi(2'd1, 4'd1));
    issue(cmp(2'd0, 2'd1));
    issue(blt(6'h3E));
    check("blt_to0_pc", pc, 8'h00);
    issue(cmp(2'd1, 2'd0));
    issue(beq(6'h0A));
    check("beq_ne_pc", pc, 8'h02);
    issue(cmp(2'd0, 2'd1));
    issue(blt(6'h3D));
    check("blt_back_pc", pc, 8'h00);
    issue(blt(6'h3F));
    check("blt_wrap_pc", pc, 8'hFF);

    // Illegal ALU word with valid held through EXEC/WB
    dc0 = done_cnt;
    ec0 = err_cnt;
    issue(alu_i(3'd4, 2'd1, 2'd1, 1'b1), 1'b1, ldi(2'd2, 4'd7));
    check("ill_done", done_cnt, dc0 + 1);
    check("ill_err", err_cnt, ec0 + 1);
    check("ill_pc", pc, 8'h00);
    expect_reg("ill_r1", 2'd1, 8'h01);
    issue(ldi(2'd2, 4'd7));
    check("hold_done", done_cnt, dc0 + 2);
    check("hold_err", err_cnt, ec0 + 1);
    expect_reg("hold_r2", 2'd2, 8'h07);
    check("hold_pc", pc, 8'h01);

    // Reset during EXEC of ADD r1,r2
    fif.insn = alu_i(3'd4, 2'd1, 2'd2, 1'b0);
    fif.insn_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    fif.insn_valid = 1'b0;
    check("mid_op", alu_op, 5'h04);
    expect_reg("mid_pre_r1", 2'd1, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid_r1", dbg_data, 8'h00);
    check("mid_pc", pc, 8'h00);
    check("mid_done", done, 1'b0);
    check("mid_ready", fif.insn_ready, 1'b1);
    check("mid_opclr", alu_op, 5'h00);
    dc0 = done_cnt;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt, dc0);
    check("mid_ready_after", fif.insn_ready, 1'b1);
    expect_reg("mid_post_r1", 2'd1, 8'h00);
    expect_reg("mid_post_r2", 2'd2, 8'h00);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
